instr_fetch_unit: RTL and testbench

- Requester side of the instruction ROM interface. Drives a word-aligned byte address into the combinational instruction memory and captures the returned word each cycle.
- Buffers fetched words with their PCs in a small prefetch FIFO and presents them to the decode stage through a valid/ready handshake.
- Handles branch redirects by flushing the FIFO. Stops fetching cleanly at the memory boundary.

---
 rtl/instr_fetch_unit.sv | 150 +++++++++++++++
 tb/tb_instr_fetch_unit.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit
//   Requester side of a combinational instruction ROM. It walks fetch_pc
//   forward one word per cycle and places each fetched word, with its PC,
//   into a small prefetch FIFO. The decode stage drains the FIFO through a
//   valid/ready handshake. A redirect flushes the FIFO and restarts fetch at
//   redirect_pc. Fetch stops at a misaligned or out-of-range address; the
//   fault is reported only after the already-fetched words have drained.
//
// Optional feature (macro IFU_PERF_CNT_EN):
//   Adds the perf_fetched and perf_stall performance counters.
//
// Ports:
//   clk            rising-edge clock
//   reset_n        asynchronous active-low reset
//   imem_addr      word-aligned byte address to the ROM (equals fetch_pc)
//   imem_instr     combinational ROM data for imem_addr
//   redirect_valid redirect request; has priority over everything else
//   redirect_pc    new fetch address, sampled when redirect_valid=1
//   out_valid      FIFO head holds a valid instruction
//   out_instr      head instruction (0 when empty)
//   out_pc         head instruction byte address (0 when empty)
//   out_ready      consumer accepts the head this cycle
//   fetch_fault    fetch stopped on a bad address and the FIFO is empty
//   perf_fetched   (IFU_PERF_CNT_EN) number of pushes, wraps at 2^32
//   perf_stall     (IFU_PERF_CNT_EN) empty, non-faulted, non-redirect cycles

module instr_fetch_unit #(
    parameter int unsigned FIFO_DEPTH        = 4,
    parameter logic [63:0] RESET_PC          = 64'h0,
    parameter int unsigned INSTRUCT_MEM_SIZE = 1024
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic [63:0] imem_addr,
    input  logic [31:0] imem_instr,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic        out_valid,
    output logic [31:0] out_instr,
    output logic [63:0] out_pc,
    input  logic        out_ready,
    output logic        fetch_fault
`ifdef IFU_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_stall
`endif
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FIFO_DEPTH);
    localparam logic [64:0]      MEM_LIMIT = 65'(INSTRUCT_MEM_SIZE);

    logic [63:0]      fetch_pc_q, fetch_pc_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             fault_flag_q, fault_flag_d;

    logic [31:0] instr_mem [FIFO_DEPTH];
    logic [63:0] pc_mem    [FIFO_DEPTH];

    logic bad;
    logic push;
    logic pop;

    // 65-bit sum so a fetch_pc near 2^64 cannot wrap past the range check.
    assign bad  = (fetch_pc_q[1:0] != 2'b00) ||
                  (({1'b0, fetch_pc_q} + 65'd3) >= MEM_LIMIT);
    assign pop  = out_valid && out_ready;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign push = !redirect_valid && !bad && !fault_flag_q &&
                  ((count_q < DEPTH_CNT) || pop);

    always_comb begin
        fetch_pc_d   = fetch_pc_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        fault_flag_d = fault_flag_q;
        if (redirect_valid) begin
            // Flush: any head accepted this cycle is discarded as well.
            fetch_pc_d   = redirect_pc;
            wr_ptr_d     = '0;
            rd_ptr_d     = '0;
            count_d      = '0;
            fault_flag_d = 1'b0;
        end else begin
            if (push) begin
                wr_ptr_d   = wr_ptr_q + PTR_W'(1);
                fetch_pc_d = fetch_pc_q + 64'd4;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
            if (bad) begin
                fault_flag_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fetch_pc_q   <= RESET_PC;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            fault_flag_q <= 1'b0;
        end else begin
            fetch_pc_q   <= fetch_pc_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            fault_flag_q <= fault_flag_d;
        end
    end

    // Storage needs no reset: entries are only visible while count is nonzero.
    always_ff @(posedge clk) begin
        if (push) begin
            instr_mem[wr_ptr_q] <= imem_instr;
            pc_mem[wr_ptr_q]    <= fetch_pc_q;
        end
    end

    assign imem_addr   = fetch_pc_q;
    assign out_valid   = (count_q != '0);
    assign out_instr   = out_valid ? instr_mem[rd_ptr_q] : 32'h0;
    assign out_pc      = out_valid ? pc_mem[rd_ptr_q] : 64'h0;
    assign fetch_fault = fault_flag_q && (count_q == '0);

`ifdef IFU_PERF_CNT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            perf_fetched <= 32'h0;
            perf_stall   <= 32'h0;
        end else begin
            if (push) begin
                perf_fetched <= perf_fetched + 32'd1;
            end
            if (!out_valid && !fault_flag_q && !redirect_valid) begin
                perf_stall <= perf_stall + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit. A queue-based reference model
// tracks which PCs sit in the prefetch buffer; a monitor compares the DUT
// against it every cycle on the falling edge.

module tb_instr_fetch_unit;

    localparam int unsigned DEPTH  = 4;
    localparam logic [63:0] RST_PC = 64'h0;
    localparam int unsigned MSIZE  = 1024;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [63:0] imem_addr;
    logic [31:0] imem_instr;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        out_valid;
    logic [31:0] out_instr;
    logic [63:0] out_pc;
    logic        out_ready;
    logic        fetch_fault;
`ifdef IFU_PERF_CNT_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_stall;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model state: FIFO as a queue of PCs, plus fetch PC and fault.
    logic [63:0] m_q[$];
    logic [63:0] m_pc;
    logic        m_fault;
    logic [31:0] m_fetched;
    logic [31:0] m_stall;

    always #5 clk = ~clk;

    // ROM contents: word k at address 4k, tagged so instr differs from pc.
    function automatic logic [31:0] rom(input logic [63:0] a);
        return a[33:2] ^ 32'hA5A5_0000;
    endfunction

    assign imem_instr = rom(imem_addr);

    instr_fetch_unit #(
        .FIFO_DEPTH       (DEPTH),
        .RESET_PC         (RST_PC),
        .INSTRUCT_MEM_SIZE(MSIZE)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .imem_addr     (imem_addr),
        .imem_instr    (imem_instr),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .out_valid     (out_valid),
        .out_instr     (out_instr),
        .out_pc        (out_pc),
        .out_ready     (out_ready),
        .fetch_fault   (fetch_fault)
`ifdef IFU_PERF_CNT_EN
        ,
        .perf_fetched  (perf_fetched),
        .perf_stall    (perf_stall)
`endif
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: applies the fetch rules at each clock edge.
    always @(posedge clk or negedge reset_n) begin : model
        bit pop, push, bad;
        if (!reset_n) begin
            m_q.delete();
            m_pc      <= RST_PC;
            m_fault   <= 1'b0;
            m_fetched <= 32'h0;
            m_stall   <= 32'h0;
        end else begin
            pop  = (m_q.size() != 0) && out_ready;
            bad  = (m_pc % 4 != 0) || (m_pc >= 64'(MSIZE) - 64'd3);
            push = !redirect_valid && !bad && !m_fault && (m_q.size() < DEPTH || pop);
            if (m_q.size() == 0 && !m_fault && !redirect_valid) m_stall <= m_stall + 1;
            if (redirect_valid) begin
                m_q.delete();
                m_pc    <= redirect_pc;
                m_fault <= 1'b0;
            end else begin
                if (pop) void'(m_q.pop_front());
                if (push) begin
                    m_q.push_back(m_pc);
                    m_pc      <= m_pc + 64'd4;
                    m_fetched <= m_fetched + 1;
                end
                if (bad) m_fault <= 1'b1;
            end
        end
    end

    // Monitor: compares DUT outputs with the model head away from the active edge.
    always @(negedge clk) begin
        if (reset_n) begin
            check("out_valid", 64'(out_valid), 64'(m_q.size() != 0));
            if (m_q.size() != 0) begin
                check("out_pc", out_pc, m_q[0]);
                check("out_instr", 64'(out_instr), 64'(rom(m_q[0])));
            end else begin
                check("empty_pc", out_pc, 64'h0);
                check("empty_instr", 64'(out_instr), 64'h0);
            end
            check("fetch_fault", 64'(fetch_fault), 64'(m_fault && m_q.size() == 0));
            check("imem_addr", imem_addr, m_pc);
`ifdef IFU_PERF_CNT_EN
            check("perf_fetched", 64'(perf_fetched), 64'(m_fetched));
            check("perf_stall", 64'(perf_stall), 64'(m_stall));
`endif
        end
    end

    // Drive inputs for one cycle; returns just after the next rising edge.
    task automatic cyc(input logic rdy, input logic rv, input logic [63:0] rpc);
        out_ready      = rdy;
        redirect_valid = rv;
        redirect_pc    = rpc;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [63:0] tgt;
        reset_n        = 1'b0;
        out_ready      = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 64'h0;
        #1;
        check("rst_valid", 64'(out_valid), 64'h0);
        check("rst_addr", imem_addr, RST_PC);
        check("rst_fault", 64'(fetch_fault), 64'h0);
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;

        // Streaming with ready held high.
        repeat (20) cyc(1'b1, 1'b0, 64'h0);

        // Back-pressure then drain.
        repeat (10) cyc(1'b0, 1'b0, 64'h0);
        repeat (10) cyc(1'b1, 1'b0, 64'h0);

        // Redirect while full with a head being accepted.
        repeat (6) cyc(1'b0, 1'b0, 64'h0);
        cyc(1'b1, 1'b1, 64'h100);
        check("redir_flush", 64'(out_valid), 64'h0);
        repeat (10) cyc(1'b1, 1'b0, 64'h0);

        // Run to the end of memory, then recover via redirect.
        cyc(1'b1, 1'b1, 64'h3E0);
        for (int i = 0; i < 100 && !fetch_fault; i++) begin
            cyc(1'($urandom_range(0, 1)), 1'b0, 64'h0);
        end
        check("end_fault", 64'(fetch_fault), 64'h1);
        check("end_addr", imem_addr, 64'h400);
        repeat (3) cyc(1'b1, 1'b0, 64'h0);
        cyc(1'b1, 1'b1, 64'h0);
        check("fault_clear", 64'(fetch_fault), 64'h0);
        repeat (5) cyc(1'b1, 1'b0, 64'h0);

        // Misaligned and overflowing redirect targets, back-to-back redirects.
        cyc(1'b1, 1'b1, 64'h102);
        cyc(1'b1, 1'b0, 64'h0);
        check("misalign_fault", 64'(fetch_fault), 64'h1);
        repeat (3) cyc(1'b1, 1'b0, 64'h0);
        cyc(1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC);
        repeat (3) cyc(1'b1, 1'b0, 64'h0);
        cyc(1'b1, 1'b1, 64'h40);
        cyc(1'b1, 1'b1, 64'h80);
        repeat (6) cyc(1'b0, 1'b0, 64'h0);
        repeat (6) cyc(1'b1, 1'b0, 64'h0);

        // Randomized traffic.
        repeat (400) begin
            case ($urandom_range(0, 3))
                0: tgt = {52'h0, 2'($urandom_range(0, 3)), 8'($urandom), 2'b00};
                1: tgt = 64'(MSIZE) - 64'(4 * $urandom_range(1, 6));
                2: tgt = {54'h0, 8'($urandom), 2'($urandom_range(1, 3))};
                default: tgt = 64'h0;
            endcase
            cyc(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 15) == 0), tgt);
        end

        // Asynchronous reset in the middle of a stream.
        cyc(1'b1, 1'b1, 64'h200);
        repeat (5) cyc(1'b1, 1'b0, 64'h0);
        out_ready = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        check("async_valid", 64'(out_valid), 64'h0);
        check("async_pc", out_pc, 64'h0);
        check("async_instr", 64'(out_instr), 64'h0);
        check("async_fault", 64'(fetch_fault), 64'h0);
        check("async_addr", imem_addr, RST_PC);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        repeat (3) cyc(1'b0, 1'b0, 64'h0);
        repeat (10) cyc(1'b1, 1'b0, 64'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
